window_reader: RTL and testbench
================================

// Module: window_reader
// PURPOSE
//  Consumer side of the row-buffer occupancy counter (len_check). Waits until the
//  occupancy count covers one window of rows, streams the rows out of the buffer
//  by address with a valid/ready handshake, then pulses the window release
//  (down_enable + start/end row address) so the counter frees the rows.
//  Sits between the row buffer and the downstream compute stage.
// PARAMETERS
//  WIDTH         4  occupancy count width; must match len_check WIDTH
//  POINTER_SIZE  4  row address width; buffer depth = 2**POINTER_SIZE
//  DATA_W        8  row data width
//  NWIN_W        8  width of window-count input
// PORTS
//  clk             in   1             rising-edge clock
//  rst_n           in   1             async reset, active-low
//  start           in   1             1-cycle pulse: begin a job
//  win_len         in   POINTER_SIZE  rows per window, 1..2**POINTER_SIZE-1
//  num_win         in   NWIN_W        windows in the job, >=1
//  count           in   WIDTH         rows available (from len_check)
//  rd_en           out  1             buffer read strobe
//  rd_addr         out  POINTER_SIZE  buffer read address
//  rd_data         in   DATA_W        buffer data, valid cycle after rd_en, held while rd_en=0
//  out_valid       out  1             out_data valid
//  out_ready       in   1             downstream accepts
//  out_data        out  DATA_W        = rd_data
//  down_enable     out  1             1-cycle window release to len_check
//  start_row_addr  out  POINTER_SIZE  first row of released window
//  end_row_addr    out  POINTER_SIZE  last row of released window
//  busy            out  1             state != IDLE
//  done            out  1             1-cycle pulse after last window released
// BEHAVIOUR
//  - Reset: state=IDLE, base=0, rd_pending=0; all outputs 0.
//  - States: IDLE -> WAIT -> READ -> RELEASE -> (WAIT | IDLE).
//  - IDLE: start && win_len!=0 && num_win!=0 samples win_len/num_win, -> WAIT;
//    otherwise start ignored. start outside IDLE always ignored.
//  - WAIT: when count (zero-extended) >= win_len -> READ next cycle;
//    rows_left=win_len, rd_addr=base.
//  - READ: rd_en = rows_left!=0 && (!rd_pending || out_ready). On rd_en: rd_addr
//    increments mod 2**POINTER_SIZE, rows_left--. rd_pending <= rd_en |
//    (rd_pending & ~out_ready). out_valid = rd_pending; out_data = rd_data.
//    Latency rd_en->out_valid: 1 cycle; peak 1 row/cycle.
//  - Backpressure: out_ready=0 holds out_valid/out_data, no rd_en; no row
//    skipped or duplicated.
//  - READ -> RELEASE when rows_left==0 && rd_pending && out_ready.
//  - RELEASE (1 cycle): down_enable=1, start_row_addr=base,
//    end_row_addr=base+win_len-1 (mod 2**POINTER_SIZE, wrap allowed);
//    base <= end_row_addr+1 (mod); windows_left--. If 0: done=1, -> IDLE;
//    else -> WAIT. start/end hold their values outside RELEASE.
//  - count may rise during any state (up_enable concurrent with down_enable
//    handled by len_check); count is not re-checked inside READ.
//  - base persists across jobs; cleared only by reset.
//  - Reset mid-operation: immediate return to reset state; in-flight row dropped.
// STRUCTURE
//  - rowbuf_pkg: typedef enum {IDLE,WAIT,READ,RELEASE} win_state_t; shared with
//    len_check users for any row-buffer constants.
//  - Single module; no sub-module (address counter and FSM are small).
// TESTING
//  1 win_len=3,num_win=1,count=3,out_ready=1 -> rd_addr 0,1,2 on 3 consecutive
//    cycles; RELEASE start=0,end=2; done next cycle; base=3.
//  2 win_len=3,count=2 -> stays WAIT, rd_en=0; count->3 -> first rd_en next cycle.
//  3 out_ready=0 for 2 cycles on beat 1 -> out_data/out_valid held, rd_en=0;
//    beats seen exactly rows 0,1,2 once each.
//  4 POINTER_SIZE=4, base=14, win_len=4 -> rd_addr 14,15,0,1; start=14,end=1; base=2.
//  5 num_win=2,win_len=2,count=4 -> two releases (0..1, 2..3), one done pulse.
//  6 rst_n low mid-READ -> all outputs 0, busy=0, base=0; start with win_len=0
//    or during busy -> ignored.

Source files
------------

// File: rtl/window_reader_pkg.sv
// ----------------------------------------------------------------------------
// window_reader_pkg
//   Shared row-buffer definitions for the window reader and for other users of
//   the len_check occupancy counter.
//   Contents:
//     win_state_t          reader FSM state encoding
//     ROWBUF_WIDTH_DEF     default occupancy count width (matches len_check)
//     ROWBUF_PTR_DEF       default row address width
//     ROWBUF_DATA_DEF      default row data width
//     ROWBUF_NWIN_DEF      default window-count width
// ----------------------------------------------------------------------------
package window_reader_pkg;

  localparam int ROWBUF_WIDTH_DEF = 4;
  localparam int ROWBUF_PTR_DEF   = 4;
  localparam int ROWBUF_DATA_DEF  = 8;
  localparam int ROWBUF_NWIN_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    READ    = 2'd2,
    RELEASE = 2'd3
  } win_state_t;

endpackage

// File: rtl/window_reader_if.sv
// ----------------------------------------------------------------------------
// window_reader_if
//   Bus bundle between the window reader, the row buffer read port, the
//   downstream compute stage and the len_check release port.
//   Signals:
//     rd_en / rd_addr / rd_data       row buffer read port (data one cycle
//                                     after rd_en, held while rd_en=0)
//     out_valid / out_ready / out_data  row stream to the compute stage
//     down_enable / start_row_addr / end_row_addr  window release to len_check
//   Modports:
//     master  window reader side
//     slave   environment side (buffer, compute stage, len_check)
// ----------------------------------------------------------------------------
interface window_reader_if #(
  parameter int POINTER_SIZE = 4,
  parameter int DATA_W       = 8
);

  logic                    rd_en;
  logic [POINTER_SIZE-1:0] rd_addr;
  logic [DATA_W-1:0]       rd_data;

  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;

  logic                    down_enable;
  logic [POINTER_SIZE-1:0] start_row_addr;
  logic [POINTER_SIZE-1:0] end_row_addr;

  modport master (
    output rd_en, rd_addr, out_valid, out_data,
           down_enable, start_row_addr, end_row_addr,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_valid, out_data,
           down_enable, start_row_addr, end_row_addr,
    output rd_data, out_ready
  );

endinterface

// File: rtl/window_reader.sv
// ----------------------------------------------------------------------------
// window_reader
//   Consumer side of the row-buffer occupancy counter. For each window of a
//   job it waits until len_check reports enough rows, streams those rows out
//   of the buffer by address with a valid/ready handshake, then pulses the
//   window release so len_check can free them.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     start           1-cycle job start (sampled only in IDLE)
//     win_len         rows per window (0 makes start ignored)
//     num_win         windows per job (0 makes start ignored)
//     count           rows currently available (from len_check)
//     bus             read port, output stream and release port (master)
//     busy            high whenever a job is in progress
//     done            1-cycle pulse the cycle after the last release
// ----------------------------------------------------------------------------
module window_reader
  import window_reader_pkg::*;
#(
  parameter int WIDTH        = ROWBUF_WIDTH_DEF,
  parameter int POINTER_SIZE = ROWBUF_PTR_DEF,
  parameter int DATA_W       = ROWBUF_DATA_DEF,
  parameter int NWIN_W       = ROWBUF_NWIN_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [POINTER_SIZE-1:0] win_len,
  input  logic [NWIN_W-1:0]       num_win,
  input  logic [WIDTH-1:0]        count,
  window_reader_if.master         bus,
  output logic                    busy,
  output logic                    done
);

  // count and win_len may differ in width; compare both zero-extended
  localparam int CMP_W = (WIDTH > POINTER_SIZE) ? WIDTH : POINTER_SIZE;

  win_state_t              state;
  win_state_t              state_nxt;

  logic [POINTER_SIZE-1:0] base;
  logic [POINTER_SIZE-1:0] rd_ptr;
  logic [POINTER_SIZE-1:0] rows_left;
  logic [POINTER_SIZE-1:0] len_q;
  logic [POINTER_SIZE-1:0] start_q;
  logic [POINTER_SIZE-1:0] end_q;
  logic [NWIN_W-1:0]       windows_left;
  logic                    rd_pending;
  logic                    done_q;

  logic                    start_ok;
  logic                    count_ok;
  logic                    rd_en_c;
  logic                    read_last;
  logic                    last_window;

  // Last row of a window starting at 'first'; wraps around the buffer.
  function automatic logic [POINTER_SIZE-1:0] win_last_row(
    input logic [POINTER_SIZE-1:0] first,
    input logic [POINTER_SIZE-1:0] len
  );
    return first + len - POINTER_SIZE'(1);
  endfunction

  // Next row address, modulo buffer depth.
  function automatic logic [POINTER_SIZE-1:0] ptr_next(
    input logic [POINTER_SIZE-1:0] ptr
  );
    return ptr + POINTER_SIZE'(1);
  endfunction

  assign start_ok    = start && (win_len != '0) && (num_win != '0);
  assign count_ok    = CMP_W'(count) >= CMP_W'(len_q);
  assign read_last   = (rows_left == '0) && rd_pending && bus.out_ready;
  assign last_window = (windows_left == NWIN_W'(1));

  // ---- FSM state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- FSM next-state ----
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_ok)  state_nxt = WAIT;
      WAIT:    if (count_ok)  state_nxt = READ;
      READ:    if (read_last) state_nxt = RELEASE;
      RELEASE: state_nxt = last_window ? IDLE : WAIT;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- FSM outputs ----
  // A new read is only issued when the row already in flight (if any) is
  // being taken this cycle, so the buffer's held data is never overwritten
  // before the consumer sees it.
  always_comb begin
    rd_en_c         = 1'b0;
    bus.down_enable = 1'b0;
    busy            = 1'b0;
    unique case (state)
      IDLE:    busy = 1'b0;
      WAIT:    busy = 1'b1;
      READ: begin
        busy    = 1'b1;
        rd_en_c = (rows_left != '0) && (!rd_pending || bus.out_ready);
      end
      RELEASE: begin
        busy            = 1'b1;
        bus.down_enable = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  assign bus.rd_en          = rd_en_c;
  assign bus.rd_addr        = rd_ptr;
  assign bus.out_valid      = rd_pending;
  // Gated so the stream presents zero whenever nothing is in flight.
  assign bus.out_data       = rd_pending ? bus.rd_data : '0;
  assign bus.start_row_addr = start_q;
  assign bus.end_row_addr   = end_q;
  assign done               = done_q;

  // ---- window bookkeeping and read pipeline ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base         <= '0;
      rd_ptr       <= '0;
      rows_left    <= '0;
      len_q        <= '0;
      start_q      <= '0;
      end_q        <= '0;
      windows_left <= '0;
      rd_pending   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      rd_pending <= rd_en_c | (rd_pending & ~bus.out_ready);
      done_q     <= (state == RELEASE) && last_window;
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            len_q        <= win_len;
            windows_left <= num_win;
          end
        end
        WAIT: begin
          if (count_ok) begin
            rows_left <= len_q;
            rd_ptr    <= base;
          end
        end
        READ: begin
          if (rd_en_c) begin
            rd_ptr    <= ptr_next(rd_ptr);
            rows_left <= rows_left - POINTER_SIZE'(1);
          end
          // Release addresses are loaded on entry to RELEASE and then held
          // until the next window's release.
          if (read_last) begin
            start_q <= base;
            end_q   <= win_last_row(base, len_q);
          end
        end
        RELEASE: begin
          base         <= ptr_next(end_q);
          windows_left <= windows_left - NWIN_W'(1);
        end
        default: begin
          rd_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_window_reader.sv
// ----------------------------------------------------------------------------
// tb_window_reader
//   Directed bench for window_reader. Stimulus pushes expected read addresses,
//   stream beats and releases into queues; a monitor pops and compares them as
//   the DUT presents them.
// ----------------------------------------------------------------------------
module tb_window_reader;

  localparam int PS = 4;
  localparam int DW = 8;
  localparam int WD = 4;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [PS-1:0] win_len;
  logic [NW-1:0] num_win;
  logic [WD-1:0] count;
  logic          busy;
  logic          done;

  window_reader_if #(.POINTER_SIZE(PS), .DATA_W(DW)) bus ();

  window_reader #(
    .WIDTH(WD), .POINTER_SIZE(PS), .DATA_W(DW), .NWIN_W(NW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
    .num_win(num_win), .count(count), .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Row buffer model: data one cycle after rd_en, held otherwise.
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int exp_done = 0;
  logic [PS-1:0] tb_base = '0;

  logic [PS-1:0]   exp_addr_q [$];
  logic [DW-1:0]   exp_data_q [$];
  logic [2*PS-1:0] exp_rel_q  [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic extra(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s act=%0h exp=none t=%0t", name, act, $time);
  endtask

  // Monitor: compare every read, accepted beat and release against queues.
  logic prev_de = 1'b0;
  always @(negedge clk) begin
    if (bus.rd_en) begin
      if (exp_addr_q.size() == 0) extra("rd_addr_extra", 32'(bus.rd_addr));
      else chk("rd_addr", 32'(bus.rd_addr), 32'(exp_addr_q.pop_front()));
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_data_q.size() == 0) extra("beat_extra", 32'(bus.out_data));
      else chk("beat_data", 32'(bus.out_data), 32'(exp_data_q.pop_front()));
    end
    if (bus.down_enable) begin
      if (exp_rel_q.size() == 0) extra("release_extra", 32'({bus.start_row_addr, bus.end_row_addr}));
      else chk("release_rows", 32'({bus.start_row_addr, bus.end_row_addr}), 32'(exp_rel_q.pop_front()));
    end
    if (done) begin
      done_cnt++;
      chk("done_after_release", 32'(prev_de), 32'd1);
    end
    prev_de = bus.down_enable;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [PS-1:0] l, input logic [NW-1:0] n);
    tick();
    win_len = l;
    num_win = n;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic start_job(input int l, input int n, input int c);
    logic [PS-1:0] first;
    logic [PS-1:0] a;
    for (int w = 0; w < n; w++) begin
      first = tb_base;
      for (int k = 0; k < l; k++) begin
        a = first + PS'(k);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(mem[a]);
      end
      exp_rel_q.push_back({first, PS'(first + PS'(l) - PS'(1))});
      tb_base = first + PS'(l);
    end
    count = WD'(c);
    pulse_start(PS'(l), NW'(n));
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    exp_done++;
    while (done_cnt < exp_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, 32'(done_cnt), 32'(exp_done));
    chk({name, "_beats_left"}, 32'(exp_data_q.size()), 32'd0);
    chk({name, "_addr_left"}, 32'(exp_addr_q.size()), 32'd0);
    chk({name, "_rel_left"}, 32'(exp_rel_q.size()), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"},     32'(bus.rd_en), 32'd0);
    chk({tag, "_rd_addr"},   32'(bus.rd_addr), 32'd0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_data"},  32'(bus.out_data), 32'd0);
    chk({tag, "_down_en"},   32'(bus.down_enable), 32'd0);
    chk({tag, "_start_row"}, 32'(bus.start_row_addr), 32'd0);
    chk({tag, "_end_row"},   32'(bus.end_row_addr), 32'd0);
    chk({tag, "_busy"},      32'(busy), 32'd0);
    chk({tag, "_done"},      32'(done), 32'd0);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    tb_base = '0;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_rel_q.delete();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic [DW-1:0] held;
    for (int i = 0; i < 16; i++) mem[i] = DW'(8'hA0 + i);
    rst_n         = 1'b0;
    start         = 1'b0;
    win_len       = '0;
    num_win       = '0;
    count         = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    tick();
    rst_n = 1'b1;

    // Basic window: rows 0,1,2 read on consecutive cycles, release 0..2.
    start_job(3, 1, 3);
    n = 0;
    while (!bus.rd_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t1_rd_en_seen", 32'(bus.rd_en), 32'd1);
    @(negedge clk);
    chk("t1_rd_en_2nd", 32'(bus.rd_en), 32'd1);
    @(negedge clk);
    chk("t1_rd_en_3rd", 32'(bus.rd_en), 32'd1);
    @(negedge clk);
    chk("t1_rd_en_stop", 32'(bus.rd_en), 32'd0);
    wait_done("t1");

    // Backpressure on the first beat, from a freshly reset base.
    do_reset();
    tick();
    bus.out_ready = 1'b0;
    start_job(3, 1, 3);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t3_valid_seen", 32'(bus.out_valid), 32'd1);
    chk("t3_first_row", 32'(bus.out_data), 32'h0A0);
    held = bus.out_data;
    repeat (2) begin
      @(negedge clk);
      chk("t3_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t3_hold_data", 32'(bus.out_data), 32'(held));
      chk("t3_hold_no_rd", 32'(bus.rd_en), 32'd0);
    end
    tick();
    bus.out_ready = 1'b1;
    wait_done("t3");

    // Count gating: stays in WAIT until count reaches win_len.
    start_job(3, 1, 2);
    repeat (4) begin
      @(negedge clk);
      chk("t2_wait_no_rd", 32'(bus.rd_en), 32'd0);
      chk("t2_wait_busy", 32'(busy), 32'd1);
    end
    tick();
    count = WD'(3);
    @(negedge clk);
    chk("t2_same_cycle_no_rd", 32'(bus.rd_en), 32'd0);
    @(negedge clk);
    chk("t2_rd_next_cycle", 32'(bus.rd_en), 32'd1);
    wait_done("t2");

    // Advance base from 6 to 14, then a window that wraps: 14,15,0,1.
    start_job(8, 1, 8);
    wait_done("fill");
    start_job(4, 1, 4);
    wait_done("t4");

    // Two windows in one job from a reset base: releases 0..1 and 2..3.
    do_reset();
    @(negedge clk);
    chk_zero("t5_reset");
    start_job(2, 2, 4);
    wait_done("t5");
    repeat (5) @(negedge clk);
    chk("t5_single_done", 32'(done_cnt), 32'(exp_done));

    // Reset in the middle of a stalled READ (base is 4 here).
    tick();
    bus.out_ready = 1'b0;
    exp_addr_q.push_back(PS'(4));
    count = WD'(3);
    pulse_start(PS'(3), NW'(1));
    repeat (6) @(negedge clk);
    chk("t6_stalled_valid", 32'(bus.out_valid), 32'd1);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("t6_midreset");
    chk("t6_addr_consumed", 32'(exp_addr_q.size()), 32'd0);
    tb_base = '0;
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    // Ignored starts: win_len=0, num_win=0, and a start while busy.
    pulse_start(PS'(0), NW'(1));
    repeat (3) @(negedge clk);
    chk("t6_len0_ignored", 32'(busy), 32'd0);
    pulse_start(PS'(2), NW'(0));
    repeat (3) @(negedge clk);
    chk("t6_nwin0_ignored", 32'(busy), 32'd0);
    start_job(2, 1, 2);
    pulse_start(PS'(5), NW'(3));
    wait_done("t6");
    repeat (6) @(negedge clk);
    chk("t6_idle_after", 32'(busy), 32'd0);
    chk("final_done_count", 32'(done_cnt), 32'(exp_done));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
